// File: rtl/tpu_tile_sequencer.sv
// rtl/tpu_tile_sequencer.sv - tile sequencer for the weight-stationary systolic array
module tpu_tile_sequencer #(
   parameter int ADDRESSSIZE  = 10,
   parameter int MATRIX_SIZE  = 16,
   parameter int WEIGHT_PIPE  = 1,
   parameter int SA_LATENCY   = 2*MATRIX_SIZE,
   parameter int NUM_TILES_BW = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic                    abort,
   input  logic [ADDRESSSIZE-1:0]  num_rows,
   input  logic [NUM_TILES_BW-1:0] num_tiles,
   input  logic [ADDRESSSIZE-1:0]  ub_base,
   input  logic [ADDRESSSIZE-1:0]  res_base,
   output logic                    fifo_read_enable,
   output logic                    we_rl,
   output logic                    ub_rd,
   output logic [ADDRESSSIZE-1:0]  ub_addr,
   output logic                    res_we,
   output logic [ADDRESSSIZE-1:0]  res_addr,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   // Phase counter must cover both the weight-load and the drain phases.
   localparam int CW = $clog2(SA_LATENCY + WEIGHT_PIPE + 3);
   localparam logic [CW-1:0] WL_LAST = CW'(WEIGHT_PIPE + 1);
   localparam logic [CW-1:0] DR_LAST = CW'(SA_LATENCY - 1);

   typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_FEED, S_DRAIN, S_DONE} state_t;

   state_t                  r_state, w_state_nxt;
   logic [ADDRESSSIZE-1:0]  r_rows, r_ub_base, r_res_base, r_off, r_i, r_j;
   logic [NUM_TILES_BW-1:0] r_tiles, r_t;
   logic [CW-1:0]           r_cnt;
   logic [SA_LATENCY-1:0]   r_dl;
   logic                    r_err_pend, r_err, r_fre, r_we_rl, r_ub_rd, r_res_we, r_busy, r_done;
   logic [ADDRESSSIZE-1:0]  r_ub_addr, r_res_addr;

   logic w_abort, w_fre, w_we_rl, w_feed, w_done, w_err, w_busy, w_res_we;
   logic w_wl_last, w_feed_last, w_dr_last, w_last_tile;

   assign w_abort     = abort && (r_state != S_IDLE);
   assign w_wl_last   = (r_cnt == WL_LAST);
   assign w_feed_last = (r_i == r_rows - ADDRESSSIZE'(1));
   assign w_dr_last   = (r_cnt == DR_LAST);
   assign w_last_tile = (r_t == r_tiles - NUM_TILES_BW'(1));
   // The delay-line tap is the write strobe; an abort kills the in-flight row.
   assign w_res_we    = r_dl[SA_LATENCY-1] && !w_abort;

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and the strobe values to be registered at the coming edge.
   always_comb begin
      w_state_nxt = r_state;
      w_fre       = 1'b0;
      w_we_rl     = 1'b0;
      w_feed      = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_busy      = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (num_rows == '0 || num_tiles == '0) w_err = 1'b1;
               else                                   w_state_nxt = S_WLOAD;
            end
         end
         S_WLOAD: begin
            w_fre   = (r_cnt == '0);
            w_we_rl = w_wl_last;
            if (w_wl_last) w_state_nxt = S_FEED;
         end
         S_FEED: begin
            w_feed = 1'b1;
            if (w_feed_last) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_dr_last) w_state_nxt = w_last_tile ? S_DONE : S_WLOAD;
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort) begin
         w_state_nxt = S_IDLE;
         w_fre       = 1'b0;
         w_we_rl     = 1'b0;
         w_feed      = 1'b0;
         w_done      = 1'b0;
      end
   end

   // Job registers, counters, delay line and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rows     <= '0;
         r_tiles    <= '0;
         r_ub_base  <= '0;
         r_res_base <= '0;
         r_off      <= '0;
         r_i        <= '0;
         r_j        <= '0;
         r_t        <= '0;
         r_cnt      <= '0;
         r_dl       <= '0;
         r_err_pend <= 1'b0;
         r_err      <= 1'b0;
         r_fre      <= 1'b0;
         r_we_rl    <= 1'b0;
         r_ub_rd    <= 1'b0;
         r_res_we   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ub_addr  <= '0;
         r_res_addr <= '0;
      end else begin
         r_err_pend <= w_err;
         r_err      <= r_err_pend;
         r_fre      <= w_fre;
         r_we_rl    <= w_we_rl;
         r_ub_rd    <= w_feed;
         r_res_we   <= w_res_we;
         r_busy     <= w_busy;
         r_done     <= w_done;
         r_dl       <= w_abort ? '0 : {r_dl[SA_LATENCY-2:0], w_feed};
         if (w_feed) r_ub_addr <= r_ub_base + r_off + r_i;
         if (w_res_we) begin
            r_res_addr <= r_res_base + r_off + r_j;
            r_j        <= r_j + ADDRESSSIZE'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_rows     <= num_rows;
                  r_tiles    <= num_tiles;
                  r_ub_base  <= ub_base;
                  r_res_base <= res_base;
                  r_t        <= '0;
                  r_i        <= '0;
                  r_off      <= '0;
                  r_cnt      <= '0;
               end
            end
            S_WLOAD: begin
               r_cnt <= w_wl_last ? '0 : r_cnt + CW'(1);
               r_i   <= '0;
               r_j   <= '0;
            end
            S_FEED: begin
               r_i   <= r_i + ADDRESSSIZE'(1);
               r_cnt <= '0;
            end
            S_DRAIN: begin
               if (w_dr_last) begin
                  r_cnt <= '0;
                  r_t   <= r_t + NUM_TILES_BW'(1);
                  r_off <= r_off + r_rows;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign fifo_read_enable = r_fre;
   assign we_rl            = r_we_rl;
   assign ub_rd            = r_ub_rd;
   assign ub_addr          = r_ub_addr;
   assign res_we           = r_res_we;
   assign res_addr         = r_res_addr;
   assign busy             = r_busy;
   assign done             = r_done;
   assign err              = r_err;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// tb/tb_tpu_tile_sequencer.sv - testbench for tpu_tile_sequencer
module tb_tpu_tile_sequencer;

   localparam int A  = 10;
   localparam int WP = 1;
   localparam int L  = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start, abort;
   logic [A-1:0]  num_rows, ub_base, res_base;
   logic [3:0]    num_tiles;
   logic          fifo_read_enable, we_rl, ub_rd, res_we, busy, done, err;
   logic [A-1:0]  ub_addr, res_addr;

   int ncheck = 0;
   int nerr   = 0;

   typedef struct {
      int rows, tiles, ub, res, abort_at, restart5, reset_at;
      int exp_err, exp_done, exp_nwr, exp_first, exp_ua, exp_ra;
   } vec_t;

   vec_t vecs[10];

   tpu_tile_sequencer dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort),
      .num_rows(num_rows), .num_tiles(num_tiles), .ub_base(ub_base), .res_base(res_base),
      .fifo_read_enable(fifo_read_enable), .we_rl(we_rl), .ub_rd(ub_rd), .ub_addr(ub_addr),
      .res_we(res_we), .res_addr(res_addr), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [26:0] pack_out();
      return {busy, done, err, fifo_read_enable, we_rl, ub_rd,
              (ub_rd ? ub_addr : 10'd0), res_we, (res_we ? res_addr : 10'd0)};
   endfunction

   // Expected outputs in cycle c, derived from the tile timetable.
   function automatic logic [26:0] model(int c, int rows, int tiles, int ub, int res,
                                         int abort_at, int reset_at);
      logic b, dn, e, f, w, rd, rw;
      logic [A-1:0] ua, ra;
      int d, dc, k, t, p;
      b = 0; dn = 0; e = 0; f = 0; w = 0; rd = 0; rw = 0; ua = '0; ra = '0;
      if (reset_at > 0 && c >= reset_at) return '0;
      if (rows == 0 || tiles == 0) begin
         e = (c == 1);
      end else begin
         d  = WP + 2 + rows + L;
         dc = 1 + tiles * d;
         if (!(abort_at > 0 && c > abort_at)) begin
            b  = (c >= 1 && c <= dc);
            dn = (c == dc);
            if (c >= 1 && c < dc) begin
               k = c - 1; t = k / d; p = k % d;
               f = (p == 0);
               w = (p == WP + 1);
               if (p >= WP + 2 && p < WP + 2 + rows) begin
                  rd = 1; ua = A'(ub + t * rows + p - WP - 2);
               end
               if (p >= WP + 2 + L && p < WP + 2 + L + rows) begin
                  rw = 1; ra = A'(res + t * rows + p - WP - 2 - L);
               end
            end
            if (abort_at > 0 && c == abort_at) begin
               dn = 0; f = 0; w = 0; rd = 0; rw = 0; ua = '0; ra = '0;
            end
         end
      end
      return {b, dn, e, f, w, rd, ua, rw, ra};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      ncheck++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_job(input int rows, input int tiles, input int ub, input int res,
                          input int abort_at, input int restart5, input int reset_at,
                          output int n_wr, output int first_wr, output int done_seen,
                          output int err_seen, output int last_ua, output int last_ra);
      int d, dc, end_c;
      logic [26:0] act, exp;
      d  = WP + 2 + rows + L;
      dc = 1 + tiles * d;
      if (rows == 0 || tiles == 0) end_c = 4;
      else if (reset_at > 0)       end_c = reset_at + 60;
      else if (abort_at > 0)       end_c = abort_at + 3;
      else                         end_c = dc + 3;
      n_wr = 0; first_wr = 0; done_seen = 0; err_seen = 0; last_ua = 0; last_ra = 0;
      @(negedge clk);
      num_rows = A'(rows); num_tiles = 4'(tiles); ub_base = A'(ub); res_base = A'(res);
      start = 1'b1; abort = 1'b0;
      for (int c = 0; c <= end_c; c++) begin
         if (c > 0) begin
            start     = (restart5 != 0 && c == 5);
            abort     = (abort_at > 0 && c == abort_at);
            num_rows  = A'($urandom);
            num_tiles = 4'($urandom);
            ub_base   = A'($urandom);
            res_base  = A'($urandom);
         end
         @(posedge clk);
         if (reset_at > 0 && c == reset_at) begin
            #1 rstn = 1'b0;
         end
         @(negedge clk);
         act = pack_out();
         exp = model(c, rows, tiles, ub, res, abort_at, reset_at);
         ncheck++;
         if (act !== exp) begin
            nerr++;
            $display("FAIL cycle %0d (rows=%0d tiles=%0d): got %h expected %h",
                     c, rows, tiles, act, exp);
         end
         if (res_we) begin
            n_wr++;
            if (first_wr == 0) first_wr = c;
            last_ra = int'(res_addr);
         end
         if (ub_rd) last_ua = int'(ub_addr);
         if (done)  done_seen = c;
         if (err)   err_seen = 1;
         if (reset_at > 0 && c == reset_at + 2) rstn = 1'b1;
      end
      start = 1'b0; abort = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n_wr, first_wr, done_seen, err_seen, last_ua, last_ra;
      int rows, tiles, dc, ab, rs;
      //          rows tiles ub     res    abort rst5 reset  err done nwr first ua     ra
      vecs[0] = '{16, 1, 'h010, 'h200, 0,  0, 0,  0, 52,  16, 36, 'h01F, 'h20F};
      vecs[1] = '{4,  2, 'h000, 'h100, 0,  0, 0,  0, 79,  8,  36, 'h007, 'h107};
      vecs[2] = '{4,  1, 'h3FE, 'h3FF, 0,  0, 0,  0, 40,  4,  36, 'h001, 'h002};
      vecs[3] = '{0,  1, 'h010, 'h200, 0,  0, 0,  1, 0,   0,  0,  0,     0};
      vecs[4] = '{4,  0, 'h010, 'h200, 0,  0, 0,  1, 0,   0,  0,  0,     0};
      vecs[5] = '{2,  3, 'h050, 'h060, 0,  0, 0,  0, 112, 6,  36, 'h055, 'h065};
      vecs[6] = '{16, 1, 'h010, 'h200, 40, 0, 0,  0, 0,   4,  36, 'h01F, 'h203};
      vecs[7] = '{16, 1, 'h010, 'h200, 0,  1, 0,  0, 52,  16, 36, 'h01F, 'h20F};
      vecs[8] = '{16, 1, 'h010, 'h200, 0,  0, 10, 0, 0,   0,  0,  'h015, 0};
      vecs[9] = '{16, 1, 'h010, 'h200, 0,  0, 0,  0, 52,  16, 36, 'h01F, 'h20F};

      rstn = 1'b0; start = 1'b0; abort = 1'b0;
      num_rows = '0; num_tiles = '0; ub_base = '0; res_base = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", int'(pack_out()), 0);
      rstn = 1'b1;

      for (int v = 0; v < 10; v++) begin
         run_job(vecs[v].rows, vecs[v].tiles, vecs[v].ub, vecs[v].res, vecs[v].abort_at,
                 vecs[v].restart5, vecs[v].reset_at,
                 n_wr, first_wr, done_seen, err_seen, last_ua, last_ra);
         chk($sformatf("vec%0d err", v),       err_seen,  vecs[v].exp_err);
         chk($sformatf("vec%0d done_cyc", v),  done_seen, vecs[v].exp_done);
         chk($sformatf("vec%0d n_writes", v),  n_wr,      vecs[v].exp_nwr);
         chk($sformatf("vec%0d first_wr", v),  first_wr,  vecs[v].exp_first);
         chk($sformatf("vec%0d last_ua", v),   last_ua,   vecs[v].exp_ua);
         chk($sformatf("vec%0d last_ra", v),   last_ra,   vecs[v].exp_ra);
      end

      for (int n = 0; n < 8; n++) begin
         rows  = int'($urandom_range(1, 20));
         tiles = int'($urandom_range(1, 3));
         dc    = 1 + tiles * (WP + 2 + rows + L);
         ab    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, dc)) : 0;
         rs    = (ab == 0 || ab >= 5) ? int'($urandom_range(0, 1)) : 0;
         run_job(rows, tiles, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 ab, rs, 0, n_wr, first_wr, done_seen, err_seen, last_ua, last_ra);
         chk($sformatf("rand%0d done_cyc", n), done_seen, (ab == 0) ? dc : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", ncheck, nerr);
      $finish;
   end

endmodule

// File: doc/tpu_tile_sequencer.md
Name: tpu_tile_sequencer

Overview:
Parametrised control sequencer for the weight-stationary systolic TPU datapath. It replaces the free-running 5-bit result counter and fixed state counter with one FSM. The FSM runs a programmable number of tiles; each tile performs a weight FIFO pop, a weight reload, a stream of N activation rows from the unified buffer, and a latency-matched capture of N result rows into result SRAM. It sits between host start/config and the UB, weight FIFO, systolic array and result SRAM.

Parameters:
ADDRESSSIZE, 10, UB and result SRAM address width
MATRIX_SIZE, 16, systolic array dimension (informational; sets SA_LATENCY default)
WEIGHT_PIPE, 1, weight fan-out pipeline stages between FIFO output and array
SA_LATENCY, 2*MATRIX_SIZE, cycles from a UB read strobe to its result row being valid at the result SRAM input (skew, array and deskew)
NUM_TILES_BW, 4, width of tile-count field

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  launch request; sampled only in IDLE
abort  in  1  synchronous cancel
num_rows  in  ADDRESSSIZE  activation rows per tile; 0 is illegal
num_tiles  in  NUM_TILES_BW  tiles per job; 0 is illegal
ub_base  in  ADDRESSSIZE  first UB read address
res_base  in  ADDRESSSIZE  first result SRAM write address
fifo_read_enable  out  1  weight FIFO pop strobe
we_rl  out  1  weight reload strobe to the array
ub_rd  out  1  UB row read strobe
ub_addr  out  ADDRESSSIZE  UB read address
res_we  out  1  result SRAM write enable
res_addr  out  ADDRESSSIZE  result SRAM write address
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at job completion
err  out  1  one-cycle pulse on an illegal start

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rstn. All outputs are registered.
- Reset: state goes to IDLE, all outputs and counters go to 0, and the result valid delay line is cleared. Reset during a job discards the job.
- Cycle numbering: cycle k is the k-th rising edge after the edge that samples start.
- IDLE: on start, latch num_rows, num_tiles, ub_base and res_base, and clear the tile index t and row index i.
  - If either count is 0: pulse err at cycle 1 and stay in IDLE (busy stays 0).
  - Otherwise go to WLOAD.
- start is ignored in all other states. Config inputs are ignored after latching.
- WLOAD: lasts WEIGHT_PIPE+2 cycles. fifo_read_enable=1 in the first cycle only; we_rl=1 in the last cycle only. Then go to FEED.
- FEED: lasts num_rows cycles.
  - ub_rd=1 each cycle.
  - ub_addr = ub_base + t*num_rows + i, truncated mod 2^ADDRESSSIZE, so addresses wrap.
  - Each read pushes a valid bit into an SA_LATENCY-deep delay line.
- Result capture: res_we is the delay-line output, so each row is written exactly SA_LATENCY cycles after its ub_rd. res_addr = res_base + t*num_rows + j, where j is the result row index, also wrapping.
- DRAIN: lasts exactly SA_LATENCY cycles after FEED. The last res_we falls in the final DRAIN cycle. Then:
  - if t+1 < num_tiles: increment t and go to WLOAD;
  - otherwise go to DONE.
- No weight reload is issued while results are in flight.
- DONE: done=1 for one cycle, then go to IDLE. busy is 0 in the following cycle.
- Tile duration = WEIGHT_PIPE + 2 + num_rows + SA_LATENCY cycles.
- abort: in any non-IDLE state, go to IDLE next cycle.
  - The delay line is flushed, so no further res_we occurs.
  - No done pulse is issued.
  - abort has priority over every other transition. abort in IDLE has no effect; abort together with start in IDLE: start wins.
- Arithmetic: the t*num_rows offset is kept as a running base accumulator (add num_rows per tile) rather than a multiplier.

Test Plan:
- Defaults; num_rows=16, num_tiles=1, ub_base=0x010, res_base=0x200 -> required response:
  - fifo_read_enable @1, we_rl @3;
  - ub_rd @4..19 with addresses 0x010..0x01F;
  - res_we @36..51 with addresses 0x200..0x20F;
  - done @52; busy high @1..52.
- num_rows=4, num_tiles=2, ub_base=0, res_base=0x100 -> required response:
  - tile0 reads @4..7 (0..3), writes @36..39 (0x100..0x103);
  - tile1 fifo_read_enable @40, we_rl @42, reads @43..46 (4..7), writes @75..78 (0x104..0x107);
  - done @79.
- Wrap: ub_base=0x3FE, res_base=0x3FF, num_rows=4 -> ub_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; res_addr sequence 0x3FF, 0x000, 0x001, 0x002.
- Illegal start, num_rows=0 or num_tiles=0 -> err pulse @1; no strobes; busy stays 0; a later legal start runs normally.
- Abort: same setup as the first case, abort asserted @40 (DRAIN) -> res_we seen @36..39 only; busy=0 @41; no done; a restart completes normally.
- Reset and re-start: rstn low @10 (mid-FEED) -> all outputs 0 immediately, no res_we afterwards. Separately, start re-asserted @5 while busy -> ignored, and the timing of the first case is unchanged.
